// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Each accepted request sends one frame:
// a start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit
// and a stop bit (1). Every bit lasts max(Prescale,1) CLK cycles, which
// matches the oversampling clock used by the companion receiver.
module uart_tx_frame #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic                   TX_OUT,
  output logic                   Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       idx_inc;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   load;

  // Frame settings captured at acceptance so later input changes cannot
  // disturb a frame that is already on the line.
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   par_en_q;
  logic                   par_typ_q;
  logic [PRESC_WIDTH-1:0] presc_q;

  logic                   bit_done;
  logic                   par_bit;

  // Last cycle of the current bit period; presc_q is never zero.
  assign bit_done = (cnt_q == presc_q - PRESC_WIDTH'(1));
  // Even parity makes the total count of ones even; odd inverts it.
  assign par_bit  = (^data_q) ^ par_typ_q;
  assign idx_inc  = idx_q + IDX_W'(1);

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    load    = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_done ? '0 : cnt_q + PRESC_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (Data_valid) begin
          load    = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = data_q[0];
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_inc;
            tx_d  = data_q[idx_inc];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and the registered line driver; reset aborts any frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= PRESC_WIDTH'(1);
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      if (load) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        presc_q   <= (Prescale == '0) ? PRESC_WIDTH'(1) : Prescale;
      end
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: a table of directed frames, random frames
// against a bit-list reference model, and hand sequences for back-to-back
// requests and asynchronous reset in the middle of a frame.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int passed = 0;
  int total  = 0;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_valid (Data_valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         pt;
    logic [5:0] presc;
    bit         disturb;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: the frame as a list of line levels, one per bit slot.
  function automatic logic model_bit(input logic [7:0] d, input bit pe, input bit pt, input int slot);
    logic par;
    par = logic'(($countones(d) % 2) != 0) ^ pt;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (slot == 9 && pe) return par;
    return 1'b1;
  endfunction

  function automatic int model_p(input logic [5:0] ps);
    return (ps == 0) ? 1 : int'(ps);
  endfunction

  // Called at the negedge in the first cycle of a frame; checks every cycle,
  // decodes the byte mid-bit, and ends at the negedge after the frame.
  task automatic capture(input string tag, input vec_t v, input bit idle_after);
    int         p, nbits, len, bad, busy_cnt, slot;
    logic [7:0] dec;
    logic       rx_par;
    p        = model_p(v.presc);
    nbits    = v.pe ? 11 : 10;
    len      = nbits * p;
    bad      = 0;
    busy_cnt = 0;
    dec      = '0;
    rx_par   = 1'bx;
    for (int k = 0; k < len; k++) begin
      slot = k / p;
      if (TX_OUT !== model_bit(v.data, v.pe, v.pt, slot)) bad++;
      if (Busy === 1'b1) busy_cnt++;
      if (k % p == p / 2) begin
        if (slot >= 1 && slot <= 8) dec[slot-1] = TX_OUT;
        if (slot == 9 && v.pe) rx_par = TX_OUT;
      end
      if (v.disturb && k == len / 2) begin
        P_DATA     = 8'hFF;
        Prescale   = 6'd8;
        PAR_EN     = ~v.pe;
        PAR_TYP    = ~v.pt;
        Data_valid = 1'b1;
      end
      if (v.disturb && k == len / 2 + 1) Data_valid = 1'b0;
      @(negedge CLK);
    end
    check({tag, "_wave_errs"}, bad, 0);
    check({tag, "_data"}, dec, v.data);
    if (v.pe) check({tag, "_parity"}, rx_par, v.exp_par);
    check({tag, "_busy_len"}, busy_cnt, v.exp_len);
    check({tag, "_end_busy"}, Busy, 1'b0);
    check({tag, "_end_tx"}, TX_OUT, 1'b1);
    if (idle_after) begin
      @(negedge CLK);
      check({tag, "_no_requeue"}, {Busy, TX_OUT}, 2'b01);
    end
  endtask

  // Issue one single-cycle request from an idle line and check the frame.
  task automatic run_frame(input string tag, input vec_t v);
    P_DATA     = v.data;
    PAR_EN     = v.pe;
    PAR_TYP    = v.pt;
    Prescale   = v.presc;
    Data_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Data_valid = 1'b0;
    capture(tag, v, 1'b1);
  endtask

  vec_t vecs[10];
  vec_t rv;
  vec_t b1, b2;

  initial begin
    // Directed frames with hand-derived lengths and parity bits.
    vecs[0] = '{8'hBB, 1'b0, 1'b0, 6'd8,  1'b0, 80,  1'b0};
    vecs[1] = '{8'h3B, 1'b1, 1'b0, 6'd16, 1'b0, 176, 1'b1};
    vecs[2] = '{8'h3B, 1'b1, 1'b1, 6'd16, 1'b0, 176, 1'b0};
    vecs[3] = '{8'h8E, 1'b1, 1'b0, 6'd8,  1'b0, 88,  1'b0};
    vecs[4] = '{8'h3B, 1'b1, 1'b1, 6'd8,  1'b0, 88,  1'b0};
    vecs[5] = '{8'h1D, 1'b0, 1'b0, 6'd8,  1'b0, 80,  1'b0};
    vecs[6] = '{8'hC3, 1'b1, 1'b1, 6'd32, 1'b1, 352, 1'b1};
    vecs[7] = '{8'h00, 1'b1, 1'b0, 6'd0,  1'b0, 11,  1'b0};
    vecs[8] = '{8'hFF, 1'b1, 1'b1, 6'd1,  1'b0, 11,  1'b1};
    vecs[9] = '{8'h80, 1'b0, 1'b0, 6'd63, 1'b0, 630, 1'b0};

    RST        = 1'b0;
    P_DATA     = 8'h00;
    Data_valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;

    repeat (2) @(negedge CLK);
    check("reset_tx", TX_OUT, 1'b1);
    check("reset_busy", Busy, 1'b0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_after_reset", {Busy, TX_OUT}, 2'b01);

    for (int i = 0; i < 10; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Data_valid held high: two frames separated by one idle-high cycle.
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    Data_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    P_DATA = 8'h5A;
    b1 = '{8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 80, 1'b0};
    capture("b2b_first", b1, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    Data_valid = 1'b0;
    b2 = '{8'h5A, 1'b0, 1'b0, 6'd8, 1'b0, 80, 1'b0};
    capture("b2b_second", b2, 1'b1);

    // Asynchronous reset during data bit 3 of a P=32 frame.
    P_DATA     = 8'hC3;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd32;
    Data_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Data_valid = 1'b0;
    repeat (4 * 32 + 10) @(negedge CLK);
    check("pre_reset_line", {Busy, TX_OUT}, 2'b10);
    #2 RST = 1'b0;
    #1;
    check("async_reset_tx", TX_OUT, 1'b1);
    check("async_reset_busy", Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("post_reset_idle", {Busy, TX_OUT}, 2'b01);
    run_frame("after_reset", '{8'h00, 1'b0, 1'b0, 6'd8, 1'b0, 80, 1'b0});

    // Random frames checked against the model.
    for (int i = 0; i < 30; i++) begin
      rv.data    = 8'($urandom);
      rv.pe      = 1'($urandom);
      rv.pt      = 1'($urandom);
      rv.presc   = 6'($urandom_range(0, 20));
      rv.disturb = 1'($urandom_range(0, 3) == 0);
      rv.exp_len = (rv.pe ? 11 : 10) * model_p(rv.presc);
      rv.exp_par = logic'(($countones(rv.data) % 2) != 0) ^ rv.pt;
      run_frame($sformatf("rand%0d", i), rv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
